tile_pixel_reader: RTL and testbench
====================================

Name: tile_pixel_reader

Overview:
- Read-side client of the tile pixel RAM (16 tiles × 16×16 px, 12 bpp, 1-cycle registered read).
- Takes the VGA timing generator's pixel stream, maps each on-board pixel to its board cell, fetches that cell's tile index from the board map, and reads the tile texel from RAM.
- Emits registered RGB444 plus sync/DE, all delayed by the same fixed 2-clock latency.
- Sits between the VGA timing block, the board-state map and the VGA pins.

Parameters:
- BOARD_X0, 240, left pixel column of the board.
- BOARD_Y0, 80, top pixel row of the board.
- BOARD_COLS, 10, board width in cells (≤16).
- BOARD_ROWS, 20, board height in cells (≤32).
- BORDER_W, 2, frame thickness in pixels drawn outside the board (0 disables).
- BG_COLOR, 12'h000, colour for background and transparent texels.
- BORDER_COLOR, 12'h888, frame colour.
- KEY_COLOR, 12'hF0F, texel value treated as transparent.
- SYNC_IDLE, 1'b1, inactive level of hsync/vsync (reset value of vga_hs/vga_vs).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- pix_de  in  1  active video
- pix_hs  in  1  hsync from timing generator
- pix_vs  in  1  vsync from timing generator
- cell_col  out  4  board column of current pixel (combinational)
- cell_row  out  5  board row of current pixel (combinational)
- tile_idx  in  4  tile number for (cell_row, cell_col), answered combinationally the same cycle
- tile_vld  in  1  cell occupied; 0 means empty cell
- ram_ren  out  1  RAM read enable
- ram_raddr  out  12  RAM read address
- ram_rdata  in  12  RAM data, valid one clock after ram_ren
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  delayed hsync
- vga_vs  out  1  delayed vsync
- vga_de  out  1  delayed DE

Behaviour:
Reset (async, rst_n=0):
- All pipeline registers clear; vga_r/g/b=0, vga_de=0, vga_hs=vga_vs=SYNC_IDLE.
- Release mid-frame: outputs become correct within 2 clocks, with no spurious RAM reads.

Stage 0 (combinational):
- in_board = pix_de && X0 ≤ pix_x < X0+COLS*16 && Y0 ≤ pix_y < Y0+ROWS*16.
- Compare before subtracting, so there is no unsigned wrap.
- rel_x = pix_x−X0, rel_y = pix_y−Y0.
- cell_col = rel_x[7:4], cell_row = rel_y[8:4] when in_board, else 0.
- ram_ren = in_board && tile_vld.
- ram_raddr = {tile_idx, rel_y[3:0], rel_x[3:0]} when ram_ren, else 12'h000.
- in_border = pix_de && !in_board && the pixel lies within BORDER_W of the board rectangle (corners included).

Stage 1 (registered):
- hit1 <= ram_ren; brd1 <= in_border; de1/hs1/vs1 <= pix_de/pix_hs/pix_vs.
- The RAM supplies ram_rdata in this cycle.

Stage 2 (registered outputs):
- !de1 → rgb 0.
- hit1 && ram_rdata≠KEY_COLOR → {r,g,b} = ram_rdata[11:8], [7:4], [3:0].
- brd1 → BORDER_COLOR.
- otherwise → BG_COLOR.
- vga_de/hs/vs <= de1/hs1/vs1.

Timing and boundaries:
- Latency is exactly 2 clocks from pix_* to vga_*, for every pixel including blanking.
- The last on-board pixel is (X0+COLS*16−1, Y0+ROWS*16−1) = (399,399) at defaults; (400,y) is off-board.
- An empty cell (tile_vld=0) never reads RAM and shows BG_COLOR.
- pix_de=0 inside the board rectangle gives no read and black output.

Decomposition:
- Shared package/include vga_defs: COLOR_W=12, TILE_SHIFT=4, TILE_ADDR_W=12, BG/BORDER/KEY colour constants, SYNC_IDLE.
- One sub-module, sync_delay (parameterised width × depth shift register with async active-low reset and per-bit reset value), instanced for {de,hs,vs} at depth 2.

Test Plan:
- rst_n=0 mid-line → vga_rgb=0, vga_hs=vga_vs=1, ram_ren=0 immediately; after release, first valid pixel appears 2 clocks later.
- (240,80), de=1, tile_idx=3, vld=1 → ram_ren=1, raddr=12'h300; rdata=12'hABC next cycle → vga_r/g/b = A/B/C two clocks after input.
- (255,95), tile 5 → raddr 12'h5FF, cell_col=0, cell_row=0; (256,96) → cell_col=1, cell_row=1.
- rdata=12'hF0F → BG 000; tile_vld=0 at (300,200) → ram_ren=0, rgb=000.
- (238,80) and (400,399) → ram_ren=0, rgb=888 (border); (235,80) → 000; (399,399) → read issued.
- Full 800×525 frame with random hs/vs/de → vga_hs/vs/de equal the inputs delayed exactly 2 clocks; ram_ren never asserted while pix_de=0.

Source files
------------

// File: rtl/tile_pixel_reader_pkg.sv
// rtl/tile_pixel_reader_pkg.sv - shared VGA/tile constants and colour select helper
package tile_pixel_reader_pkg;

  localparam int COLOR_W     = 12;
  localparam int TILE_SHIFT  = 4;
  localparam int TILE_ADDR_W = 12;

  localparam logic [COLOR_W-1:0] BG_COLOR_DEF     = 12'h000;
  localparam logic [COLOR_W-1:0] BORDER_COLOR_DEF = 12'h888;
  localparam logic [COLOR_W-1:0] KEY_COLOR_DEF    = 12'hF0F;
  localparam logic               SYNC_IDLE_DEF    = 1'b1;

  typedef struct packed {
    logic hit;
    logic brd;
    logic de;
  } stage1_t;

  // Priority: blanking, opaque texel, frame, background.
  function automatic logic [COLOR_W-1:0] pick_color(
    input logic               de,
    input logic               hit,
    input logic               brd,
    input logic [COLOR_W-1:0] texel,
    input logic [COLOR_W-1:0] key,
    input logic [COLOR_W-1:0] border,
    input logic [COLOR_W-1:0] bg
  );
    logic [COLOR_W-1:0] c;
    c = bg;
    if (!de)                     c = '0;
    else if (hit && texel != key) c = texel;
    else if (brd)                 c = border;
    return c;
  endfunction

endpackage

// File: rtl/tile_pixel_reader_if.sv
// rtl/tile_pixel_reader_if.sv - read port of the tile pixel RAM
interface tile_pixel_reader_if
  import tile_pixel_reader_pkg::*;
;
  logic                   ram_ren;
  logic [TILE_ADDR_W-1:0] ram_raddr;
  logic [COLOR_W-1:0]     ram_rdata;

  modport master (output ram_ren, output ram_raddr, input ram_rdata);
  modport slave  (input ram_ren, input ram_raddr, output ram_rdata);
endinterface

// File: rtl/tile_pixel_reader_sync_delay.sv
// rtl/tile_pixel_reader_sync_delay.sv - width x depth shift register with per-bit reset value
module tile_pixel_reader_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_pixel_reader.sv
// rtl/tile_pixel_reader.sv - maps VGA pixels to board cells, fetches tile texels, emits RGB444
module tile_pixel_reader
  import tile_pixel_reader_pkg::*;
#(
  parameter int                 BOARD_X0     = 240,
  parameter int                 BOARD_Y0     = 80,
  parameter int                 BOARD_COLS   = 10,
  parameter int                 BOARD_ROWS   = 20,
  parameter int                 BORDER_W     = 2,
  parameter logic [COLOR_W-1:0] BG_COLOR     = BG_COLOR_DEF,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = BORDER_COLOR_DEF,
  parameter logic [COLOR_W-1:0] KEY_COLOR    = KEY_COLOR_DEF,
  parameter logic               SYNC_IDLE    = SYNC_IDLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_de,
  input  logic       pix_hs,
  input  logic       pix_vs,
  output logic [3:0] cell_col,
  output logic [4:0] cell_row,
  input  logic [3:0] tile_idx,
  input  logic       tile_vld,
  tile_pixel_reader_if.master ram,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de
);

  localparam int TILE_PX = 1 << TILE_SHIFT;
  localparam int X_END   = BOARD_X0 + BOARD_COLS * TILE_PX;
  localparam int Y_END   = BOARD_Y0 + BOARD_ROWS * TILE_PX;
  localparam int BX_LO   = (BOARD_X0 > BORDER_W) ? BOARD_X0 - BORDER_W : 0;
  localparam int BY_LO   = (BOARD_Y0 > BORDER_W) ? BOARD_Y0 - BORDER_W : 0;
  localparam int BX_HI   = X_END + BORDER_W;
  localparam int BY_HI   = Y_END + BORDER_W;

  // 11-bit bounds keep the right/bottom edges representable without wrap.
  localparam logic [10:0] X0_C  = 11'(BOARD_X0);
  localparam logic [10:0] Y0_C  = 11'(BOARD_Y0);
  localparam logic [10:0] XE_C  = 11'(X_END);
  localparam logic [10:0] YE_C  = 11'(Y_END);
  localparam logic [10:0] BXL_C = 11'(BX_LO);
  localparam logic [10:0] BYL_C = 11'(BY_LO);
  localparam logic [10:0] BXH_C = 11'(BX_HI);
  localparam logic [10:0] BYH_C = 11'(BY_HI);

  logic [10:0] px, py;
  logic        in_board, in_box, in_border, ren_c;
  logic [7:0]  rel_x;
  logic [8:0]  rel_y;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};

  // Range tests happen on raw coordinates; the subtraction is only used once inside.
  assign in_board  = pix_de && (px >= X0_C) && (px < XE_C) && (py >= Y0_C) && (py < YE_C);
  assign in_box    = (px >= BXL_C) && (px < BXH_C) && (py >= BYL_C) && (py < BYH_C);
  assign in_border = pix_de && !in_board && in_box;

  assign rel_x = 8'(pix_x - 10'(BOARD_X0));
  assign rel_y = 9'(pix_y - 10'(BOARD_Y0));

  assign cell_col = in_board ? rel_x[7:TILE_SHIFT] : '0;
  assign cell_row = in_board ? rel_y[8:TILE_SHIFT] : '0;

  // Reads are suppressed while reset is held so a mid-frame reset never touches the RAM.
  assign ren_c         = rst_n && in_board && tile_vld;
  assign ram.ram_ren   = ren_c;
  assign ram.ram_raddr = ren_c ? {tile_idx, rel_y[TILE_SHIFT-1:0], rel_x[TILE_SHIFT-1:0]} : '0;

  stage1_t            s1_d, s1_q;
  logic [COLOR_W-1:0] rgb_d, rgb_q;

  always_comb begin
    s1_d     = '0;
    s1_d.hit = ren_c;
    s1_d.brd = in_border;
    s1_d.de  = pix_de;
  end

  always_comb begin
    rgb_d = '0;
    rgb_d = pick_color(s1_q.de, s1_q.hit, s1_q.brd, ram.ram_rdata,
                       KEY_COLOR, BORDER_COLOR, BG_COLOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      rgb_q <= '0;
    end else begin
      s1_q  <= s1_d;
      rgb_q <= rgb_d;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;

  tile_pixel_reader_sync_delay #(
    .WIDTH  (3),
    .DEPTH  (2),
    .RST_VAL({1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i ({pix_de, pix_hs, pix_vs}),
    .dout_o({vga_de, vga_hs, vga_vs})
  );

endmodule

// File: tb/tb_tile_pixel_reader.sv
// tb/tb_tile_pixel_reader.sv - vector table plus scoreboard bench for tile_pixel_reader
module tb_tile_pixel_reader;

  typedef struct {
    int          x;
    int          y;
    bit          de;
    logic [3:0]  idx;
    bit          vld;
    bit          e_ren;
    logic [11:0] e_addr;
    logic [3:0]  e_col;
    logic [4:0]  e_row;
    logic [11:0] e_rgb;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    bit          de;
    bit          hs;
    bit          vs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       pix_de, pix_hs, pix_vs;
  logic [3:0] cell_col;
  logic [4:0] cell_row;
  logic [3:0] tile_idx;
  logic       tile_vld;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de;

  tile_pixel_reader_if ram_if ();

  tile_pixel_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_de   (pix_de),
    .pix_hs   (pix_hs),
    .pix_vs   (pix_vs),
    .cell_col (cell_col),
    .cell_row (cell_row),
    .tile_idx (tile_idx),
    .tile_vld (tile_vld),
    .ram      (ram_if),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b),
    .vga_hs   (vga_hs),
    .vga_vs   (vga_vs),
    .vga_de   (vga_de)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [4096];
  logic [11:0] rd_q;
  always @(posedge clk) if (ram_if.ram_ren) rd_q <= mem[ram_if.ram_raddr];
  assign ram_if.ram_rdata = rd_q;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  vec_t tv[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model(input int x, input int y, input bit de,
                                input logic [3:0] idx, input bit vld,
                                output bit ren, output logic [11:0] addr,
                                output logic [3:0] col, output logic [4:0] row,
                                output logic [11:0] rgb);
    bit inb, brd;
    int rx, ry;
    inb  = de && x >= 240 && x < 400 && y >= 80 && y < 400;
    brd  = de && !inb && x >= 238 && x < 402 && y >= 78 && y < 402;
    rx   = x - 240;
    ry   = y - 80;
    col  = inb ? 4'(rx >> 4) : 4'd0;
    row  = inb ? 5'(ry >> 4) : 5'd0;
    ren  = inb && vld;
    addr = ren ? {idx, 4'(ry & 15), 4'(rx & 15)} : 12'h000;
    if (!de)                                rgb = 12'h000;
    else if (ren && mem[addr] != 12'hF0F)   rgb = mem[addr];
    else if (brd)                           rgb = 12'h888;
    else                                    rgb = 12'h000;
  endfunction

  task automatic apply(input int x, input int y, input bit de, input bit hs, input bit vs,
                       input logic [3:0] idx, input bit vld);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    pix_de   = de;
    pix_hs   = hs;
    pix_vs   = vs;
    tile_idx = idx;
    tile_vld = vld;
    #1;
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("vga_rgb", {vga_r, vga_g, vga_b}, e.rgb);
      check("vga_de", vga_de, e.de);
      check("vga_hs", vga_hs, e.hs);
      check("vga_vs", vga_vs, e.vs);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_out();
  endtask

  task automatic drive_model(input int x, input int y, input bit de, input bit hs, input bit vs,
                             input logic [3:0] idx, input bit vld);
    bit          ren;
    logic [11:0] addr, rgb;
    logic [3:0]  col;
    logic [4:0]  row;
    exp_t        e;
    model(x, y, de, idx, vld, ren, addr, col, row, rgb);
    apply(x, y, de, hs, vs, idx, vld);
    check("ram_ren", ram_if.ram_ren, ren);
    check("ram_raddr", ram_if.ram_raddr, addr);
    check("cell_col", cell_col, col);
    check("cell_row", cell_row, row);
    e.rgb = rgb; e.de = de; e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    check({tag, "_hs"}, vga_hs, 1'b1);
    check({tag, "_vs"}, vga_vs, 1'b1);
    check({tag, "_de"}, vga_de, 1'b0);
    check({tag, "_ren"}, ram_if.ram_ren, 1'b0);
  endtask

  // Release on a falling edge; the first output cycle after release still shows idle values.
  task automatic release_reset();
    exp_t idle;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    idle.rgb = 12'h000; idle.de = 1'b0; idle.hs = 1'b1; idle.vs = 1'b1;
    exp_q.push_back(idle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'((i * 37 + 5) ^ 12'h5A5);
    mem[12'h300] = 12'hABC;
    mem[12'h5FF] = 12'h123;
    mem[12'h700] = 12'hF0F;
    mem[12'h28C] = 12'hF00;
    mem[12'h9FF] = 12'h456;

    tv[0]  = '{240, 80,  1'b1, 4'h3, 1'b1, 1'b1, 12'h300, 4'd0, 5'd0,  12'hABC};
    tv[1]  = '{255, 95,  1'b1, 4'h5, 1'b1, 1'b1, 12'h5FF, 4'd0, 5'd0,  12'h123};
    tv[2]  = '{256, 96,  1'b1, 4'h7, 1'b1, 1'b1, 12'h700, 4'd1, 5'd1,  12'h000};
    tv[3]  = '{300, 200, 1'b1, 4'h0, 1'b0, 1'b0, 12'h000, 4'd3, 5'd7,  12'h000};
    tv[4]  = '{300, 200, 1'b1, 4'h2, 1'b1, 1'b1, 12'h28C, 4'd3, 5'd7,  12'hF00};
    tv[5]  = '{238, 80,  1'b1, 4'h4, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h888};
    tv[6]  = '{400, 399, 1'b1, 4'h4, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h888};
    tv[7]  = '{235, 80,  1'b1, 4'h4, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h000};
    tv[8]  = '{399, 399, 1'b1, 4'h9, 1'b1, 1'b1, 12'h9FF, 4'd9, 5'd19, 12'h456};
    tv[9]  = '{239, 79,  1'b1, 4'h1, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h888};
    tv[10] = '{401, 401, 1'b1, 4'h1, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h888};
    tv[11] = '{402, 300, 1'b1, 4'h1, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h000};
    tv[12] = '{240, 80,  1'b0, 4'h3, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h000};
    tv[13] = '{320, 240, 1'b0, 4'h3, 1'b1, 1'b0, 12'h000, 4'd0, 5'd0,  12'h000};

    rst_n = 1'b0;
    apply(320, 240, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1);
    #11;
    check_reset_state("por");
    release_reset();
    drive_model(240, 80, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1);

    for (int i = 0; i < 14; i++) begin
      exp_t e;
      step();
      apply(tv[i].x, tv[i].y, tv[i].de, 1'b1, 1'b1, tv[i].idx, tv[i].vld);
      check($sformatf("v%0d_ren", i), ram_if.ram_ren, tv[i].e_ren);
      check($sformatf("v%0d_raddr", i), ram_if.ram_raddr, tv[i].e_addr);
      check($sformatf("v%0d_col", i), cell_col, tv[i].e_col);
      check($sformatf("v%0d_row", i), cell_row, tv[i].e_row);
      e.rgb = tv[i].e_rgb; e.de = tv[i].de; e.hs = 1'b1; e.vs = 1'b1;
      exp_q.push_back(e);
    end

    // Mid-line reset while an on-board read is being requested.
    step();
    drive_model(320, 240, 1'b1, 1'b1, 1'b1, 4'h6, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    check_reset_state("midrst_hold");
    release_reset();
    drive_model(240, 80, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
    step();
    drive_model(241, 80, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1);

    begin
      int lines[8] = '{78, 79, 80, 240, 399, 400, 401, 402};
      foreach (lines[l]) begin
        for (int x = 0; x < 800; x++) begin
          step();
          drive_model(x, lines[l], (x < 640) && (lines[l] < 480),
                      !(x >= 656 && x < 752), !(lines[l] >= 490 && lines[l] < 492),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end
      end
    end

    for (int n = 0; n < 6000; n++) begin
      step();
      drive_model(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (2) begin
      step();
      drive_model(0, 0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
